// File: rtl/vigenere_pkg.sv
// Shared types and character helpers for the Vigenere stream cipher.
package vigenere_pkg;

  typedef enum logic {ENC = 1'b0, DEC = 1'b1} cipher_mode_e;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} cipher_state_e;

  localparam logic [5:0] ALPHA_LEN  = 6'd26;
  localparam logic [7:0] UPPER_BASE = 8'h41;
  localparam logic [7:0] LOWER_BASE = 8'h61;

  function automatic logic is_upper(input logic [7:0] b);
    return (b >= UPPER_BASE) && (b <= 8'h5A);
  endfunction

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= LOWER_BASE) && (b <= 8'h7A);
  endfunction

  function automatic logic is_letter(input logic [7:0] b);
    return is_upper(b) || is_lower(b);
  endfunction

endpackage

// File: rtl/vigenere_shift_char.sv
// Combinational single-character Vigenere shift, case preserving.
module vigenere_shift_char
  import vigenere_pkg::*;
(
  input  logic [7:0] in_byte,
  input  logic [7:0] key_byte,
  input  logic       mode,
  output logic [7:0] out_byte,
  output logic       in_is_letter
);

  logic [7:0] base;
  logic [5:0] s;
  logic [5:0] p;
  logic [5:0] c;

  // Letter codes differ from their case base only in the low 6 bits.
  always_comb begin
    s            = 6'd0;
    c            = 6'd0;
    in_is_letter = is_letter(in_byte);
    base         = is_upper(in_byte) ? UPPER_BASE : LOWER_BASE;
    p            = in_byte[5:0] - base[5:0];
    if (is_letter(key_byte)) begin
      s = (key_byte[5:0] | 6'h20) - LOWER_BASE[5:0];
    end
    if (mode == DEC) begin
      c = (p < s) ? (p + ALPHA_LEN - s) : (p - s);
    end else begin
      c = p + s;
      if (c >= ALPHA_LEN) begin
        c = c - ALPHA_LEN;
      end
    end
    out_byte = in_is_letter ? (base + {2'b00, c}) : in_byte;
  end

endmodule

// File: rtl/vigenere_stream_cipher.sv
// Streaming Vigenere encrypt/decrypt engine: key register file, key index,
// two-state FSM and a single output register on a valid/ready stream.
module vigenere_stream_cipher
  import vigenere_pkg::*;
#(
  parameter int MAX_KEY_LEN = 16,
  parameter int KIDX_W      = $clog2(MAX_KEY_LEN),
  parameter int KLEN_W      = $clog2(MAX_KEY_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_we,
  input  logic [KIDX_W-1:0] key_waddr,
  input  logic [7:0]        key_wdata,
  input  logic [KLEN_W-1:0] key_len,
  input  logic              mode,
  input  logic              start,
  output logic              busy,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last
);

  cipher_state_e     state_q, state_d;
  cipher_mode_e      mode_q;
  logic [KLEN_W-1:0] key_len_q;
  logic [KIDX_W-1:0] idx_q;
  logic [7:0]        key_mem [MAX_KEY_LEN];
  logic [7:0]        shifted;
  logic              char_is_letter;
  logic              start_ok;
  logic              in_fire;
  logic              start_idle;

  assign start_ok   = (key_len != '0) && (int'(key_len) <= MAX_KEY_LEN);
  assign start_idle = start && (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign in_ready   = (state_q == RUN) && (!out_valid || out_ready);
  assign in_fire    = in_valid && in_ready;

  vigenere_shift_char u_shift (
    .in_byte      (in_data),
    .key_byte     (key_mem[idx_q]),
    .mode         (mode_q),
    .out_byte     (shifted),
    .in_is_letter (char_is_letter)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && start_ok) state_d = RUN;
      RUN:     if (in_fire && in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Keys reset to "A" so an unprogrammed key acts as a zero shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_KEY_LEN; i++) key_mem[i] <= UPPER_BASE;
    end else if (key_we && (state_q == IDLE) && (int'(key_waddr) < MAX_KEY_LEN)) begin
      key_mem[key_waddr] <= key_wdata;
    end
  end

  // Only letters consume a key character; punctuation leaves the index alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= ENC;
      key_len_q <= KLEN_W'(1);
      idx_q     <= '0;
      cfg_err   <= 1'b0;
    end else if (start_idle) begin
      if (start_ok) begin
        mode_q    <= cipher_mode_e'(mode);
        key_len_q <= key_len;
        idx_q     <= '0;
        cfg_err   <= 1'b0;
      end else begin
        cfg_err   <= 1'b1;
      end
    end else if (in_fire && char_is_letter) begin
      if (KLEN_W'(idx_q) == key_len_q - KLEN_W'(1)) idx_q <= '0;
      else                                          idx_q <= idx_q + KIDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= shifted;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vigenere_stream_cipher.sv
// Scoreboard bench for vigenere_stream_cipher with a modular-arithmetic reference model.
module tb_vigenere_stream_cipher;

  localparam int MAX_KEY_LEN = 16;

  logic       clk;
  logic       rst_n;
  logic       key_we;
  logic [3:0] key_waddr;
  logic [7:0] key_wdata;
  logic [4:0] key_len;
  logic       mode;
  logic       start;
  logic       busy;
  logic       cfg_err;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  vigenere_stream_cipher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_we    (key_we),
    .key_waddr (key_waddr),
    .key_wdata (key_wdata),
    .key_len   (key_len),
    .mode      (mode),
    .start     (start),
    .busy      (busy),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] exp_q[$];
  logic [7:0] cap_q[$];
  int         bp_mode = 0;
  int         stall_cycles = 0;
  logic [7:0] model_key [MAX_KEY_LEN];
  int         model_len = 1;
  int         model_idx = 0;
  bit         model_dec = 1'b0;
  logic [8:0] mon_exp;
  bit         stall_prev = 1'b0;
  logic [8:0] stall_word;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic bit tb_letter(input logic [7:0] b);
    return (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  // Reference: alphabet position arithmetic modulo 26, key index walks over letters only.
  function automatic logic [7:0] ref_cipher(input logic [7:0] b);
    int base, p, s, c;
    logic [7:0] k;
    if (!tb_letter(b)) return b;
    base = (b <= 8'h5A) ? 65 : 97;
    p = int'(b) - base;
    k = model_key[model_idx];
    s = tb_letter(k) ? (int'(k | 8'h20) - 97) : 0;
    c = model_dec ? ((p - s + 26) % 26) : ((p + s) % 26);
    model_idx = (model_idx + 1) % model_len;
    return 8'(base + c);
  endfunction

  task automatic writeKeyArr(input logic [7:0] k [MAX_KEY_LEN], input int len);
    for (int i = 0; i < len; i++) begin
      key_we    = 1'b1;
      key_waddr = 4'(i);
      key_wdata = k[i];
      @(posedge clk); #1;
      model_key[i] = k[i];
    end
    key_we = 1'b0;
  endtask

  task automatic writeKey(input string k);
    logic [7:0] arr [MAX_KEY_LEN];
    for (int i = 0; i < MAX_KEY_LEN; i++) arr[i] = (i < k.len()) ? k[i] : 8'h41;
    writeKeyArr(arr, k.len());
  endtask

  task automatic startMsg(input int len, input bit dec);
    key_len = 5'(len);
    mode    = dec;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    if (len >= 1 && len <= MAX_KEY_LEN) begin
      model_len = len;
      model_idx = 0;
      model_dec = dec;
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input bit last);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    @(negedge clk);
    while (!in_ready) begin
      waited++;
      stall_cycles++;
      if (waited > 500) begin
        checkOutput("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    exp_q.push_back({last, ref_cipher(b)});
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic applyStimulus(input string msg);
    for (int i = 0; i < msg.len(); i++) sendByte(msg[i], i == msg.len() - 1);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_empty", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic checkString(input string name, input string expv);
    checkOutput({name, "_len"}, cap_q.size(), expv.len());
    for (int i = 0; i < expv.len() && i < cap_q.size(); i++)
      checkOutput(name, cap_q[i], expv[i]);
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("out_data", out_data, mon_exp[7:0]);
        checkOutput("out_last", out_last, mon_exp[8]);
      end
      cap_q.push_back(out_data);
    end
  end

  // A stalled output must hold its contents and block the input side.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("hold_valid", out_valid, 32'd1);
        checkOutput("hold_data", {out_last, out_data}, stall_word);
      end
      if (out_valid && !out_ready) begin
        checkOutput("stall_in_ready", in_ready, 32'd0);
        stall_prev = 1'b1;
        stall_word = {out_last, out_data};
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_mode == 0)      out_ready = 1'b1;
    else if (bp_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] rkey [MAX_KEY_LEN];
    logic [7:0] msg  [200];
    logic [7:0] enc  [200];
    int         rlen;

    rst_n = 1'b0; key_we = 1'b0; key_waddr = '0; key_wdata = '0; key_len = '0;
    mode = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < MAX_KEY_LEN; i++) model_key[i] = 8'h41;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 32'd0);
    checkOutput("rst_cfg_err", cfg_err, 32'd0);
    checkOutput("rst_out_valid", out_valid, 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_last", out_last, 32'd0);
    checkOutput("rst_in_ready", in_ready, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unprogrammed key is all "A": identity shift.
    startMsg(3, 1'b0);
    cap_q.delete();
    applyStimulus("Hi!z");
    waitDrain();
    checkString("default_key", "Hi!z");

    writeKey("KEY");
    startMsg(3, 1'b0);
    cap_q.delete();
    stall_cycles = 0;
    applyStimulus("HeLlOwOrLd");
    checkOutput("throughput_stalls", stall_cycles, 32'd0);
    waitDrain();
    checkString("enc_hello", "RiJvSuYvJn");
    checkOutput("busy_after_last", busy, 32'd0);

    startMsg(3, 1'b1);
    cap_q.delete();
    applyStimulus("RiJvSuYvJn");
    waitDrain();
    checkString("dec_hello", "HeLlOwOrLd");

    startMsg(3, 1'b0);
    cap_q.delete();
    applyStimulus("Hi, Yo");
    waitDrain();
    checkString("punct", "Rm, Wy");

    writeKey("B");
    startMsg(1, 1'b0);
    cap_q.delete();
    applyStimulus("zZ");
    waitDrain();
    checkString("wrap", "aA");

    startMsg(0, 1'b0);
    checkOutput("len0_cfg_err", cfg_err, 32'd1);
    checkOutput("len0_busy", busy, 32'd0);
    startMsg(17, 1'b0);
    checkOutput("len17_cfg_err", cfg_err, 32'd1);
    checkOutput("len17_busy", busy, 32'd0);
    startMsg(1, 1'b0);
    checkOutput("valid_start_clears", cfg_err, 32'd0);
    checkOutput("valid_start_busy", busy, 32'd1);
    cap_q.delete();
    applyStimulus("Q");
    waitDrain();
    checkString("single_byte", "R");

    // Three cycles of sink backpressure in the middle of a stream.
    writeKey("KEY");
    startMsg(3, 1'b0);
    cap_q.delete();
    stall_cycles = 0;
    bp_mode = 2;
    out_ready = 1'b1;
    fork
      applyStimulus("StallTest");
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    checkOutput("stall_seen", stall_cycles >= 3, 32'd1);
    waitDrain();
    checkOutput("stall_count", cap_q.size(), 32'd9);
    bp_mode = 0;

    // Reset in the middle of a message.
    startMsg(3, 1'b0);
    cap_q.delete();
    sendByte("H", 1'b0);
    sendByte("e", 1'b0);
    sendByte("L", 1'b0);
    sendByte("l", 1'b0);
    checkOutput("pre_rst_valid", out_valid, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", out_valid, 32'd0);
    checkOutput("mid_rst_busy", busy, 32'd0);
    exp_q.delete();
    for (int i = 0; i < MAX_KEY_LEN; i++) model_key[i] = 8'h41;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_rst_valid", out_valid, 32'd0);
    writeKey("KEY");
    startMsg(3, 1'b0);
    cap_q.delete();
    applyStimulus("HeLl");
    waitDrain();
    checkString("restart", "RiJv");

    // Random key and text, encrypt then decrypt with random backpressure.
    bp_mode = 1;
    rlen = $urandom_range(1, MAX_KEY_LEN);
    for (int i = 0; i < MAX_KEY_LEN; i++) begin
      if ($urandom_range(0, 4) == 0) rkey[i] = 8'($urandom_range(32, 126));
      else if ($urandom_range(0, 1) == 0) rkey[i] = 8'($urandom_range(65, 90));
      else rkey[i] = 8'($urandom_range(97, 122));
    end
    writeKeyArr(rkey, rlen);
    for (int i = 0; i < 200; i++) msg[i] = 8'($urandom_range(32, 126));
    startMsg(rlen, 1'b0);
    cap_q.delete();
    for (int i = 0; i < 200; i++) sendByte(msg[i], i == 199);
    waitDrain();
    checkOutput("rt_enc_count", cap_q.size(), 32'd200);
    for (int i = 0; i < 200; i++) enc[i] = (i < cap_q.size()) ? cap_q[i] : 8'h00;
    startMsg(rlen, 1'b1);
    cap_q.delete();
    for (int i = 0; i < 200; i++) sendByte(enc[i], i == 199);
    waitDrain();
    checkOutput("rt_dec_count", cap_q.size(), 32'd200);
    for (int i = 0; i < 200 && i < cap_q.size(); i++)
      checkOutput("roundtrip", cap_q[i], msg[i]);
    bp_mode = 0;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
